traffic_light_monitor: RTL and testbench

Passive checker on the light-code side of the intersection controller. It samples the two 2-bit light-code buses (LA, LB) every clock and decodes them back into controller phases. It checks conflicts, illegal codes, phase-transition order and dwell timing, then reports sticky error flags plus phase, dwell and cycle-count telemetry. It sits beside the controller in the same clock domain and never drives the lights.

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/traffic_light_monitor_if.sv | 35 +++
 rtl/tl_phase_decode.sv | 32 +++
 rtl/traffic_light_monitor.sv | 138 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Brief    : Light codes, phase encodings and helpers shared by the
//            intersection controller and its monitor.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam logic [1:0] c_red     = 2'b00;
    localparam logic [1:0] c_yellow  = 2'b01;
    localparam logic [1:0] c_green   = 2'b10;
    localparam logic [1:0] c_illegal = 2'b11;

    // A phase value is only meaningful while its companion phase_valid is high.
    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;

    function automatic logic is_yellow(input phase_t p);
        return (p == P1) || (p == P3);
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(2'(p + 2'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor_if
// Brief    : Light-code inputs and telemetry/error outputs of the monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       LA;
    logic [1:0]       LB;
    logic             clear;
    logic             locked;
    logic [1:0]       phase;
    logic [CNT_W-1:0] dwell;
    logic [15:0]      cycle_count;
    logic             err_code;
    logic             err_conflict;
    logic             err_seq;
    logic             err_timing;
    logic             irq;

    modport master (
        output LA, LB, clear,
        input  locked, phase, dwell, cycle_count,
        input  err_code, err_conflict, err_seq, err_timing, irq
    );

    modport slave (
        input  LA, LB, clear,
        output locked, phase, dwell, cycle_count,
        output err_code, err_conflict, err_seq, err_timing, irq
    );
endinterface
`default_nettype wire

// File: rtl/tl_phase_decode.sv
`default_nettype none
// ============================================================================
// Module   : tl_phase_decode
// Brief    : Combinational decode of {LA,LB} into a phase plus error class.
// Revision : 1.0 - initial release
// ============================================================================
module tl_phase_decode
    import traffic_pkg::*;
(
    input  wire logic [1:0] LA,
    input  wire logic [1:0] LB,
    output phase_t          phase,
    output logic            phase_valid,
    output logic            code_err,
    output logic            conflict
);

    // Priority: code error masks conflict, both mask the phase.
    always_comb begin
        code_err    = (LA == c_illegal) || (LB == c_illegal);
        conflict    = !code_err && (LA != c_red) && (LB != c_red);
        phase_valid = !code_err && !conflict && ((LA != c_red) || (LB != c_red));
        phase       = P0;
        if (LA != c_red) begin
            phase = (LA == c_green) ? P0 : P1;
        end else if (LB != c_red) begin
            phase = (LB == c_green) ? P2 : P3;
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor
// Brief    : Passive checker of light-code order, dwell and conflicts.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int YELLOW_CYCLES = 1,
    parameter int MAX_GREEN     = 64,
    parameter int CNT_W         = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    traffic_light_monitor_if.slave mon
);

    localparam logic [CNT_W-1:0] c_dwell_max    = '1;
    localparam logic [CNT_W-1:0] c_dwell_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_yellow_dwell = CNT_W'(YELLOW_CYCLES);
    localparam logic [CNT_W-1:0] c_max_green    = CNT_W'(MAX_GREEN);

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        TRACK    = 1'b1
    } mon_state_t;

    mon_state_t       r_state;
    phase_t           r_phase;
    logic [CNT_W-1:0] r_dwell;
    logic [15:0]      r_cycle_count;
    logic             r_err_code;
    logic             r_err_conflict;
    logic             r_err_seq;
    logic             r_err_timing;

    phase_t           w_dec_phase;
    logic             w_phase_valid;
    logic             w_code_err;
    logic             w_conflict;
    logic             w_same;
    logic             w_step;
    logic             w_tracking;
    logic             w_no_phase;
    logic             w_dwell_hold;
    logic [CNT_W-1:0] w_dwell_next;
    logic             w_set_seq;
    logic             w_yellow_bad;
    logic             w_watchdog;
    logic             w_rotation;

    tl_phase_decode u_decode (
        .LA          (mon.LA),
        .LB          (mon.LB),
        .phase       (w_dec_phase),
        .phase_valid (w_phase_valid),
        .code_err    (w_code_err),
        .conflict    (w_conflict)
    );

    always_comb begin
        w_same       = (w_dec_phase == r_phase);
        w_step       = (w_dec_phase == next_phase(r_phase));
        w_tracking   = (r_state == TRACK) && w_phase_valid;
        w_no_phase   = !w_code_err && !w_conflict && !w_phase_valid;
        w_dwell_hold = w_tracking && w_same && (r_dwell == c_dwell_max);
        w_dwell_next = (w_tracking && w_same)
                     ? (w_dwell_hold ? r_dwell : r_dwell + 1'b1)
                     : c_dwell_one;
        // Yellow self-loops are legal here; over-dwell is judged on exit.
        w_set_seq    = (r_state == TRACK)
                     && (w_no_phase || (w_phase_valid && !w_same && !w_step));
        w_yellow_bad = w_tracking && !w_same && is_yellow(r_phase)
                     && (r_dwell != c_yellow_dwell);
        w_watchdog   = (MAX_GREEN != 0) && w_phase_valid && !is_yellow(w_dec_phase)
                     && !w_dwell_hold && (w_dwell_next == c_max_green);
        w_rotation   = w_tracking && (r_phase == P3) && (w_dec_phase == P0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= UNLOCKED;
            r_phase        <= P0;
            r_dwell        <= '0;
            r_cycle_count  <= '0;
            r_err_code     <= 1'b0;
            r_err_conflict <= 1'b0;
            r_err_seq      <= 1'b0;
            r_err_timing   <= 1'b0;
        end else begin
            // A new error outranks a simultaneous clear.
            r_err_code     <= (r_err_code     & ~mon.clear) | w_code_err;
            r_err_conflict <= (r_err_conflict & ~mon.clear) | w_conflict;
            r_err_seq      <= (r_err_seq      & ~mon.clear) | w_set_seq;
            r_err_timing   <= (r_err_timing   & ~mon.clear) | w_yellow_bad | w_watchdog;

            if (w_rotation) begin
                r_cycle_count <= r_cycle_count + 16'd1;
            end

            case (r_state)
                UNLOCKED: begin
                    if (w_phase_valid) begin
                        r_state <= TRACK;
                        r_phase <= w_dec_phase;
                        r_dwell <= c_dwell_one;
                    end
                end
                TRACK: begin
                    if (w_phase_valid) begin
                        r_phase <= w_dec_phase;
                        r_dwell <= w_dwell_next;
                    end else begin
                        // Phase holds its last value for post-mortem telemetry.
                        r_state <= UNLOCKED;
                        r_dwell <= '0;
                    end
                end
                default: begin
                    r_state <= UNLOCKED;
                end
            endcase
        end
    end

    assign mon.locked       = (r_state == TRACK);
    assign mon.phase        = r_phase;
    assign mon.dwell        = r_dwell;
    assign mon.cycle_count  = r_cycle_count;
    assign mon.err_code     = r_err_code;
    assign mon.err_conflict = r_err_conflict;
    assign mon.err_seq      = r_err_seq;
    assign mon.err_timing   = r_err_timing;
    assign mon.irq          = r_err_code | r_err_conflict | r_err_seq | r_err_timing;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_monitor
// Brief    : Scoreboard bench for traffic_light_monitor (YELLOW=1, MAX_GREEN=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;
    import traffic_pkg::*;

    localparam int CNT_W = 8;

    localparam logic [3:0] E_NONE = 4'b0000;
    localparam logic [3:0] E_CODE = 4'b1000;
    localparam logic [3:0] E_CONF = 4'b0100;
    localparam logic [3:0] E_SEQ  = 4'b0010;
    localparam logic [3:0] E_TIM  = 4'b0001;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] X = 2'b11;

    typedef struct packed {
        logic             locked;
        logic [1:0]       phase;
        logic [CNT_W-1:0] dwell;
        logic [15:0]      cc;
        logic [3:0]       err;
        logic             irq;
    } obs_t;

    typedef struct {
        logic [1:0] la;
        logic [1:0] lb;
        logic       clr;
        obs_t       exp;
    } stim_t;

    logic clk = 1'b0;
    logic reset;

    traffic_light_monitor_if #(.CNT_W(CNT_W)) mon ();

    traffic_light_monitor #(
        .YELLOW_CYCLES (1),
        .MAX_GREEN     (8),
        .CNT_W         (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon)
    );

    always #5 clk = ~clk;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    int    checks = 0;
    int    fails  = 0;

    function automatic obs_t mk(input logic l, input phase_t p, input int d,
                                input int cc, input logic [3:0] e);
        obs_t o;
        o.locked = l;
        o.phase  = p;
        o.dwell  = CNT_W'(d);
        o.cc     = 16'(cc);
        o.err    = e;
        o.irq    = |e;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.locked = mon.locked;
        o.phase  = mon.phase;
        o.dwell  = mon.dwell;
        o.cc     = mon.cycle_count;
        o.err    = {mon.err_code, mon.err_conflict, mon.err_seq, mon.err_timing};
        o.irq    = mon.irq;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("lock=%0b ph=%0d dw=%0d cc=%0d err(code,conf,seq,tim)=%b irq=%0b",
                         o.locked, o.phase, o.dwell, o.cc, o.err, o.irq);
    endfunction

    function automatic void add(input logic [1:0] la, input logic [1:0] lb,
                                input logic clr, input obs_t e);
        stim_t s;
        s.la  = la;
        s.lb  = lb;
        s.clr = clr;
        s.exp = e;
        stim_q.push_back(s);
    endfunction

    task automatic drive(input logic [1:0] la, input logic [1:0] lb, input logic clr);
        mon.LA    = la;
        mon.LB    = lb;
        mon.clear = clr;
        @(posedge clk);
        #1;
        mon.clear = 1'b0;
    endtask

    task automatic apply_reset();
        mon.LA    = R;
        mon.LB    = R;
        mon.clear = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t e;
        mon.LA    = G;
        mon.LB    = G;
        mon.clear = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        e   = mk(1'b0, P0, 0, 0, E_NONE);
        got = sample();
        checks++;
        if (got !== e) begin
            fails++;
            $display("FAIL reset_state: got %s, expected %s", fmt(got), fmt(e));
        end
        mon.LA    = R;
        mon.LB    = R;
        mon.clear = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_normal_rotation();
        stim_t s;
        obs_t  got;
        obs_t  e;
        int    step = 0;
        for (int i = 1; i <= 5; i++) add(G, R, 1'b0, mk(1'b1, P0, i, 0, E_NONE));
        add(Y, R, 1'b0, mk(1'b1, P1, 1, 0, E_NONE));
        for (int i = 1; i <= 3; i++) add(R, G, 1'b0, mk(1'b1, P2, i, 0, E_NONE));
        add(R, Y, 1'b0, mk(1'b1, P3, 1, 0, E_NONE));
        add(G, R, 1'b0, mk(1'b1, P0, 1, 1, E_NONE));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            exp_q.push_back(s.exp);
            drive(s.la, s.lb, s.clr);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL normal_rotation[%0d]: got %s, expected %s", step, fmt(got), fmt(e));
            end
            step++;
        end
    endtask

    task automatic test_conflict();
        stim_t s;
        obs_t  got;
        obs_t  e;
        int    step = 0;
        add(G, G, 1'b0, mk(1'b0, P0, 0, 1, E_CONF));
        add(G, R, 1'b0, mk(1'b1, P0, 1, 1, E_CONF));
        add(G, R, 1'b1, mk(1'b1, P0, 2, 1, E_NONE));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            exp_q.push_back(s.exp);
            drive(s.la, s.lb, s.clr);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL conflict[%0d]: got %s, expected %s", step, fmt(got), fmt(e));
            end
            step++;
        end
    endtask

    task automatic test_seq_skip();
        stim_t s;
        obs_t  got;
        obs_t  e;
        int    step = 0;
        add(G, R, 1'b0, mk(1'b1, P0, 3, 1, E_NONE));
        add(R, G, 1'b0, mk(1'b1, P2, 1, 1, E_SEQ));
        add(R, Y, 1'b0, mk(1'b1, P3, 1, 1, E_SEQ));
        add(R, Y, 1'b1, mk(1'b1, P3, 2, 1, E_NONE));
        add(G, R, 1'b0, mk(1'b1, P0, 1, 2, E_TIM));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            exp_q.push_back(s.exp);
            drive(s.la, s.lb, s.clr);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL seq_skip[%0d]: got %s, expected %s", step, fmt(got), fmt(e));
            end
            step++;
        end
    endtask

    task automatic test_yellow_over_dwell();
        stim_t s;
        obs_t  got;
        obs_t  e;
        int    step = 0;
        apply_reset();
        add(G, R, 1'b0, mk(1'b1, P0, 1, 0, E_NONE));
        add(Y, R, 1'b0, mk(1'b1, P1, 1, 0, E_NONE));
        add(Y, R, 1'b0, mk(1'b1, P1, 2, 0, E_NONE));
        add(R, G, 1'b0, mk(1'b1, P2, 1, 0, E_TIM));
        add(R, G, 1'b1, mk(1'b1, P2, 2, 0, E_NONE));
        add(R, Y, 1'b0, mk(1'b1, P3, 1, 0, E_NONE));
        add(R, Y, 1'b0, mk(1'b1, P3, 2, 0, E_NONE));
        add(R, G, 1'b0, mk(1'b1, P2, 1, 0, E_SEQ | E_TIM));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            exp_q.push_back(s.exp);
            drive(s.la, s.lb, s.clr);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL yellow_dwell[%0d]: got %s, expected %s", step, fmt(got), fmt(e));
            end
            step++;
        end
    endtask

    task automatic test_watchdog_code();
        stim_t s;
        obs_t  got;
        obs_t  e;
        int    step = 0;
        apply_reset();
        for (int i = 1; i <= 9; i++)
            add(G, R, 1'b0, mk(1'b1, P0, i, 0, (i >= 8) ? E_TIM : E_NONE));
        add(X, R, 1'b0, mk(1'b0, P0, 0, 0, E_CODE | E_TIM));
        add(X, G, 1'b1, mk(1'b0, P0, 0, 0, E_CODE));
        add(R, R, 1'b1, mk(1'b0, P0, 0, 0, E_NONE));
        add(R, G, 1'b0, mk(1'b1, P2, 1, 0, E_NONE));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            exp_q.push_back(s.exp);
            drive(s.la, s.lb, s.clr);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL watchdog_code[%0d]: got %s, expected %s", step, fmt(got), fmt(e));
            end
            step++;
        end
    endtask

    task automatic test_clear_reset();
        stim_t s;
        obs_t  got;
        obs_t  e;
        int    step = 0;
        apply_reset();
        add(G, R, 1'b0, mk(1'b1, P0, 1, 0, E_NONE));
        add(R, G, 1'b0, mk(1'b1, P2, 1, 0, E_SEQ));
        add(G, G, 1'b1, mk(1'b0, P2, 0, 0, E_CONF));
        add(G, R, 1'b0, mk(1'b1, P0, 1, 0, E_CONF));
        add(Y, R, 1'b0, mk(1'b1, P1, 1, 0, E_CONF));
        add(R, G, 1'b0, mk(1'b1, P2, 1, 0, E_CONF));
        add(R, G, 1'b0, mk(1'b1, P2, 2, 0, E_CONF));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            exp_q.push_back(s.exp);
            drive(s.la, s.lb, s.clr);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL clear_reset[%0d]: got %s, expected %s", step, fmt(got), fmt(e));
            end
            step++;
        end

        // Asynchronous reset mid-P2, observed before any clock edge.
        reset = 1'b1;
        #1;
        e   = mk(1'b0, P0, 0, 0, E_NONE);
        got = sample();
        checks++;
        if (got !== e) begin
            fails++;
            $display("FAIL async_reset: got %s, expected %s", fmt(got), fmt(e));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        add(R, G, 1'b0, mk(1'b1, P2, 1, 0, E_NONE));
        add(R, R, 1'b0, mk(1'b0, P2, 0, 0, E_SEQ));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            exp_q.push_back(s.exp);
            drive(s.la, s.lb, s.clr);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL relock[%0d]: got %s, expected %s", step, fmt(got), fmt(e));
            end
            step++;
        end
    endtask

    task automatic test_back_to_back_saturation();
        stim_t s;
        obs_t  got;
        obs_t  e;
        int    step = 0;
        apply_reset();
        for (int i = 1; i <= 260; i++)
            add(R, G, 1'b0, mk(1'b1, P2, (i > 255) ? 255 : i, 0, (i >= 8) ? E_TIM : E_NONE));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            exp_q.push_back(s.exp);
            drive(s.la, s.lb, s.clr);
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL saturation[%0d]: got %s, expected %s", step, fmt(got), fmt(e));
            end
            step++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        mon.LA    = R;
        mon.LB    = R;
        mon.clear = 1'b0;
        test_reset();
        test_normal_rotation();
        test_conflict();
        test_seq_skip();
        test_yellow_over_dwell();
        test_watchdog_code();
        test_clear_reset();
        test_back_to_back_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
